// File: rtl/pipe_method_dispatch.sv
// pipe_method_dispatch: decodes a method index from header bits [15:8] of each
// pipe message and routes the argument (payload[ARG_WIDTH-1:0]) into one of
// NUM_METHODS per-channel FIFOs. A one-entry staging register sits between the
// pipe and the FIFOs; a full target FIFO blocks the stage (head-of-line).
// Optional feature macro: PIPE_DISPATCH_ERRCNT_EN adds the saturating
// err_count output counting discarded bad-index messages.
module pipe_method_dispatch #(
  parameter int unsigned NUM_METHODS = 4,
  parameter int unsigned HDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned ARG_WIDTH   = 32,
  parameter int unsigned DEPTH       = 2
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             pipe_enq__ENA,
  input  logic [HDR_WIDTH+DATA_WIDTH-1:0]  pipe_enq_v,
  output logic                             pipe_enq__RDY,
  output logic [NUM_METHODS-1:0]           method__ENA,
  output logic [NUM_METHODS*ARG_WIDTH-1:0] method_v,
  input  logic [NUM_METHODS-1:0]           method__RDY
`ifdef PIPE_DISPATCH_ERRCNT_EN
  ,
  output logic [15:0]                      err_count
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IdxW = 8;

  logic [IdxW-1:0]      in_idx;
  logic [ARG_WIDTH-1:0] in_arg;
  logic                 unused_bits;

  assign in_idx      = pipe_enq_v[DATA_WIDTH+15:DATA_WIDTH+8];
  assign in_arg      = pipe_enq_v[ARG_WIDTH-1:0];
  // Remaining header and payload bits are intentionally ignored.
  assign unused_bits = ^pipe_enq_v;

  logic                 stg_valid_q, stg_valid_d;
  logic [IdxW-1:0]      stg_idx_q, stg_idx_d;
  logic [ARG_WIDTH-1:0] stg_arg_q, stg_arg_d;

  logic [PtrW:0]        wptr_q [NUM_METHODS];
  logic [PtrW:0]        wptr_d [NUM_METHODS];
  logic [PtrW:0]        rptr_q [NUM_METHODS];
  logic [PtrW:0]        rptr_d [NUM_METHODS];
  logic [ARG_WIDTH-1:0] mem_q  [NUM_METHODS][DEPTH];
  logic [ARG_WIDTH-1:0] mem_d  [NUM_METHODS][DEPTH];

  logic [NUM_METHODS-1:0] empty, full, pop, push;
  logic                   stg_bad, stg_go;

  // FIFO status, pop strobes and head data presented to each method.
  always_comb begin
    for (int i = 0; i < NUM_METHODS; i++) begin
      empty[i] = (wptr_q[i] == rptr_q[i]);
      full[i]  = (wptr_q[i][PtrW] != rptr_q[i][PtrW]) &&
                 (wptr_q[i][PtrW-1:0] == rptr_q[i][PtrW-1:0]);
      pop[i]   = !empty[i] && method__RDY[i];
      method__ENA[i] = pop[i];
      method_v[i*ARG_WIDTH +: ARG_WIDTH] = empty[i] ? '0 : mem_q[i][rptr_q[i][PtrW-1:0]];
    end
  end

  // Dispatch decision: bad index drops immediately, good index needs FIFO room.
  always_comb begin
    stg_bad = stg_valid_q && ({1'b0, stg_idx_q} >= 9'(NUM_METHODS));
    for (int i = 0; i < NUM_METHODS; i++) begin
      push[i] = stg_valid_q && !stg_bad && (stg_idx_q == IdxW'(i)) && (!full[i] || pop[i]);
    end
    stg_go        = stg_bad || (|push);
    pipe_enq__RDY = !stg_valid_q || stg_go;
  end

  // Next state for staging register, pointers and FIFO storage.
  always_comb begin
    stg_valid_d = stg_valid_q;
    stg_idx_d   = stg_idx_q;
    stg_arg_d   = stg_arg_q;
    mem_d       = mem_q;
    if (pipe_enq__ENA) begin
      stg_valid_d = 1'b1;
      stg_idx_d   = in_idx;
      stg_arg_d   = in_arg;
    end else if (stg_go) begin
      stg_valid_d = 1'b0;
    end
    for (int i = 0; i < NUM_METHODS; i++) begin
      wptr_d[i] = wptr_q[i] + {{PtrW{1'b0}}, push[i]};
      rptr_d[i] = rptr_q[i] + {{PtrW{1'b0}}, pop[i]};
      if (push[i]) mem_d[i][wptr_q[i][PtrW-1:0]] = stg_arg_q;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stg_valid_q <= 1'b0;
      stg_idx_q   <= '0;
      stg_arg_q   <= '0;
      for (int i = 0; i < NUM_METHODS; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_idx_q   <= stg_idx_d;
      stg_arg_q   <= stg_arg_d;
      for (int i = 0; i < NUM_METHODS; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
      end
    end
  end

  // Storage needs no reset: head data is masked while a FIFO is empty.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

`ifdef PIPE_DISPATCH_ERRCNT_EN
  logic [15:0] err_q, err_d;

  // Saturating count of discarded bad-index messages.
  always_comb begin
    err_d = err_q;
    if (stg_bad && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
  end

  // Error counter register, cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_pipe_method_dispatch.sv
// Randomized/directed bench for pipe_method_dispatch against a queue-based
// transaction model (one queue per channel plus a one-slot staging model).
module tb_pipe_method_dispatch;

  localparam int NM    = 4;
  localparam int HW    = 16;
  localparam int DW    = 128;
  localparam int AW    = 32;
  localparam int DEPTH = 2;

  logic              CLK = 1'b0;
  logic              RST;
  logic              pipe_enq__ENA;
  logic [HW+DW-1:0]  pipe_enq_v;
  logic              pipe_enq__RDY;
  logic [NM-1:0]     method__ENA;
  logic [NM*AW-1:0]  method_v;
  logic [NM-1:0]     method__RDY;
`ifdef PIPE_DISPATCH_ERRCNT_EN
  logic [15:0]       err_count;
`endif

  pipe_method_dispatch #(
    .NUM_METHODS(NM), .HDR_WIDTH(HW), .DATA_WIDTH(DW), .ARG_WIDTH(AW), .DEPTH(DEPTH)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .pipe_enq__ENA(pipe_enq__ENA),
    .pipe_enq_v(pipe_enq_v),
    .pipe_enq__RDY(pipe_enq__RDY),
    .method__ENA(method__ENA),
    .method_v(method_v),
    .method__RDY(method__RDY)
`ifdef PIPE_DISPATCH_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [AW-1:0] mq [NM][$];
  bit            m_stg_v;
  int            m_stg_idx;
  logic [AW-1:0] m_stg_arg;
  int            m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NM; i++) mq[i].delete();
    m_stg_v = 0;
    m_err   = 0;
  endtask

  // One cycle: drive inputs at negedge, compare against model, advance model.
  task automatic step(input bit want, input logic [7:0] idx, input logic [AW-1:0] arg,
                      input logic [NM-1:0] rdy, output bit took);
    logic [NM-1:0] exp_ena;
    bit            exp_rdy;
    bit            bad;
    bit            room;
    @(negedge CLK);
    method__RDY = rdy;
    for (int i = 0; i < NM; i++) exp_ena[i] = (mq[i].size() > 0) && rdy[i];
    bad  = m_stg_v && (m_stg_idx >= NM);
    room = 0;
    if (m_stg_v && !bad)
      room = (mq[m_stg_idx].size() - (exp_ena[m_stg_idx] ? 1 : 0)) < DEPTH;
    exp_rdy = !m_stg_v || bad || room;
    took = want && exp_rdy;
    pipe_enq__ENA = took;
    pipe_enq_v    = {idx, 8'($urandom), $urandom, $urandom, $urandom, arg};
    #1;
    check("enq_rdy", 64'(pipe_enq__RDY), 64'(exp_rdy));
    check("method_ena", 64'(method__ENA), 64'(exp_ena));
    for (int i = 0; i < NM; i++)
      if (exp_ena[i]) check($sformatf("method_v%0d", i), 64'(method_v[i*AW +: AW]), 64'(mq[i][0]));
`ifdef PIPE_DISPATCH_ERRCNT_EN
    check("err_count", 64'(err_count), 64'(m_err));
`endif
    for (int i = 0; i < NM; i++) if (exp_ena[i]) void'(mq[i].pop_front());
    if (m_stg_v) begin
      if (bad) begin
        if (m_err < 65535) m_err++;
        m_stg_v = 0;
      end else if (room) begin
        mq[m_stg_idx].push_back(m_stg_arg);
        m_stg_v = 0;
      end
    end
    if (took) begin
      m_stg_v   = 1;
      m_stg_idx = int'(idx);
      m_stg_arg = arg;
    end
  endtask

  bit            tk;
  logic [AW-1:0] a;
  logic [7:0]    ix;

  initial begin
    RST = 1'b1;
    pipe_enq__ENA = 1'b0;
    pipe_enq_v = '0;
    method__RDY = '0;
    model_clear();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    method__RDY = '1;
    #1;
    check("rst_enq_rdy", 64'(pipe_enq__RDY), 64'd1);
    check("rst_ena", 64'(method__ENA), 64'd0);
    check("rst_v", 64'(method_v), 64'd0);
`ifdef PIPE_DISPATCH_ERRCNT_EN
    check("rst_err", 64'(err_count), 64'd0);
`endif
    repeat (2) step(0, 8'h00, '0, '1, tk);

    // Single message to method 2, delivered two cycles after acceptance.
    step(1, 8'h02, 32'hDEADBEEF, 4'b0100, tk);
    step(0, 8'h00, '0, 4'b0100, tk);
    step(0, 8'h00, '0, 4'b0100, tk);
    check("m2_delivered", 64'(mq[2].size()), 64'd0);
    repeat (2) step(0, 8'h00, '0, '1, tk);

    // Fill FIFO 1 and block staging, then drain in order.
    step(1, 8'h01, 32'hAAAA0001, 4'b0000, tk);
    step(1, 8'h01, 32'hBBBB0002, 4'b0000, tk);
    step(1, 8'h01, 32'hCCCC0003, 4'b0000, tk);
    step(1, 8'h01, 32'hDDDD0004, 4'b0000, tk);
    check("hol_blocked", 64'(tk), 64'd0);
    step(0, 8'h00, '0, 4'b0000, tk);
    repeat (5) step(0, 8'h00, '0, 4'b0010, tk);

    // Bad index is dropped without stalling.
    step(1, 8'h07, 32'h12345678, '1, tk);
    repeat (3) step(0, 8'h00, '0, '1, tk);
`ifdef PIPE_DISPATCH_ERRCNT_EN
    check("err_one", 64'(err_count), 64'd1);
    for (int n = 0; n < 65535; n++) step(1, 8'hF0, 32'h0, '1, tk);
    repeat (2) step(0, 8'h00, '0, '1, tk);
    check("err_sat", 64'(err_count), 64'hFFFF);
`endif

    // Back-to-back stream alternating channels 0 and 3.
    for (int n = 0; n < 20; n++) begin
      step(1, (n % 2 == 0) ? 8'h00 : 8'h03, 32'h5000_0000 + 32'(n), '1, tk);
      check("stream_took", 64'(tk), 64'd1);
    end
    repeat (3) step(0, 8'h00, '0, '1, tk);

    // Random traffic, including bad indices and random back-pressure.
    for (int n = 0; n < 3000; n++) begin
      a  = $urandom;
      ix = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      step(($urandom_range(0, 3) != 0), ix, a, 4'($urandom), tk);
    end
    repeat (8) step(0, 8'h00, '0, '1, tk);

    // Reset mid-operation with FIFO 0 full and staging occupied.
    step(1, 8'h00, 32'h0000A0A0, 4'b0000, tk);
    step(1, 8'h00, 32'h0000B0B0, 4'b0000, tk);
    step(1, 8'h00, 32'h0000C0C0, 4'b0000, tk);
    check("pre_rst_fill", 64'(mq[0].size()), 64'd2);
    @(negedge CLK);
    pipe_enq__ENA = 1'b0;
    method__RDY = '1;
    RST = 1'b1;
    #1;
    check("midrst_enq_rdy", 64'(pipe_enq__RDY), 64'd1);
    check("midrst_ena", 64'(method__ENA), 64'd0);
    check("midrst_v", 64'(method_v), 64'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_clear();
    repeat (6) step(0, 8'h00, '0, '1, tk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_method_dispatch.md
Name: pipe_method_dispatch

Overview:
- Parametrised successor to the single-method pipe-to-method converter.
- Accepts header+payload pipe messages and decodes a method index from the header.
- Routes each message's argument to one of NUM_METHODS independent method channels, each buffered by its own FIFO.
- Sits between the host request pipe and a multi-method DUT, replacing one converter per method.

Parameters:
- NUM_METHODS, 4, number of method channels; range 1..256.
- HDR_WIDTH, 16, pipe header width; method index is header bits [15:8].
- DATA_WIDTH, 128, pipe payload width.
- ARG_WIDTH, 32, method argument width; taken from payload bits [ARG_WIDTH-1:0]; ARG_WIDTH <= DATA_WIDTH.
- DEPTH, 2, entries per channel FIFO; power of two, >= 2.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- pipe$enq__ENA  in  1  pipe message valid; asserted only while pipe$enq__RDY=1.
- pipe$enq$v  in  HDR_WIDTH+DATA_WIDTH  message; header occupies the MSBs.
- pipe$enq__RDY  out  1  block can accept a message this cycle.
- method__ENA  out  NUM_METHODS  per-channel call strobe.
- method$v  out  NUM_METHODS*ARG_WIDTH  per-channel argument; channel i occupies slice i.
- method__RDY  in  NUM_METHODS  per-channel callee ready.
- err_count  out  16  dropped-message count; present only with the optional feature.

Behaviour:
- Reset (asynchronous assert, synchronous deassert):
  - staging register empty.
  - All FIFOs empty; all pointers 0.
  - method__ENA=0, method$v=0, pipe$enq__RDY=1 in the first cycle after reset.
  - err_count=0.
- Reset mid-operation: all buffered messages are discarded and none are delivered after reset.
- Staging stage:
  - One-entry register holding {index, argument}.
  - pipe$enq__RDY = staging empty OR staging dispatches this cycle.
  - pipe$enq__RDY never depends on pipe$enq$v or pipe$enq__ENA.
- Dispatch:
  - When staging is valid with index k < NUM_METHODS, it writes FIFO k if that FIFO is not full, or is full but popping this cycle.
  - Otherwise staging holds and blocks new input. This is head-of-line blocking by design.
- Bad index (k >= NUM_METHODS):
  - Staging entry is discarded in the cycle it is valid and never stalls.
  - Counted per the optional feature.
- Method side:
  - method__ENA[i] = FIFO i non-empty AND method__RDY[i].
  - method$v slice i = FIFO i head, driven continuously; value is don't-care-zero when the FIFO is empty.
  - Pop on method__ENA[i].
- Latency:
  - Message accepted in cycle t is in staging at t+1.
  - FIFO is written at the end of t+1.
  - Earliest method__ENA is cycle t+2.
  - Sustained throughput is 1 message/cycle while target FIFOs drain.
- FIFO boundaries:
  - Full with push and pop in the same cycle: both succeed and occupancy is unchanged.
  - Empty: only a push can occur; there is no write-to-output bypass.
  - Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.
- Ordering: FIFO order within a channel; no ordering guarantee across channels.
- Header bits other than [15:8] are ignored; payload bits above ARG_WIDTH are ignored.

Optional Feature:
- Macro: PIPE_DISPATCH_ERRCNT_EN.
- Defined:
  - err_count port is present.
  - Increments by 1 per discarded bad-index message and saturates at 16'hFFFF.
  - Cleared only by RST.
- Undefined:
  - Port and counter are absent.
  - Bad-index messages are silently dropped.
  - All other behaviour is identical.

Test Plan:
- Reset then idle -> pipe$enq__RDY=1, method__ENA=0, err_count=0.
- Send header 16'h0200 with arg 32'hDEADBEEF, method__RDY[2]=1 -> method__ENA[2] pulses at t+2 with method$v slice 2 = 32'hDEADBEEF; no other ENA asserts.
- Hold method__RDY[1]=0 and send 3 messages to index 1 (DEPTH=2) -> FIFO fills; third stays in staging; pipe$enq__RDY=0. Release RDY -> args delivered in order A,B,C on consecutive cycles.
- Send index 7 with NUM_METHODS=4, ERRCNT enabled -> no ENA asserts; err_count becomes 1. Preload counter to 16'hFFFF and send another -> remains 16'hFFFF.
- Back-to-back stream alternating indices 0 and 3, all RDY=1 -> one delivery per cycle after 2-cycle fill; pipe$enq__RDY stays 1.
- Assert RST while FIFO 0 holds 2 entries and staging is full -> all outputs return to reset values immediately; after release no stale ENA occurs.
